display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 tb/tb_display_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed BCD display scanner with tear-free frame commit
// A pending value is promoted to the shown value only at frame end, so a frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_sel,
  output logic        frame_commit
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_pending;
  logic [15:0]   r_shown;
  logic          r_pend_flag;
  logic [3:0]    r_bcd;
  logic [3:0]    r_sel_pre;
  logic [3:0]    r_digit_sel;
  logic          r_commit;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [3:0]    w_onehot;

  assign w_tick      = (r_div_cnt == CW'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && (r_idx == 2'd3);
  assign w_onehot    = 4'b0001 << r_idx;

  // Leading-zero test looks at the current digit and everything above it.
  always_comb begin
    w_digit = 4'h0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit = r_shown[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = r_shown[7:4];
        w_blank = (r_shown[15:4] == 12'h000);
      end
      2'd2: begin
        w_digit = r_shown[11:8];
        w_blank = (r_shown[15:8] == 8'h00);
      end
      default: begin
        w_digit = r_shown[15:12];
        w_blank = (r_shown[15:12] == 4'h0);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // A load landing on the frame-end cycle bypasses pending and commits immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending   <= 16'h0000;
      r_shown     <= 16'h0000;
      r_pend_flag <= 1'b0;
      r_commit    <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (w_frame_end && load) begin
        r_pending   <= value;
        r_shown     <= value;
        r_pend_flag <= 1'b0;
        r_commit    <= 1'b1;
      end else if (w_frame_end && r_pend_flag) begin
        r_shown     <= r_pending;
        r_pend_flag <= 1'b0;
        r_commit    <= 1'b1;
      end else if (load) begin
        r_pending   <= value;
        r_pend_flag <= 1'b1;
      end
    end
  end

  // digit_sel trails bcd by one cycle to match the segment decoder's register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bcd       <= 4'h0;
      r_sel_pre   <= 4'b0000;
      r_digit_sel <= 4'b0000;
    end else begin
      r_bcd       <= w_digit;
      r_sel_pre   <= (blank_lz && w_blank) ? 4'b0000 : w_onehot;
      r_digit_sel <= r_sel_pre;
    end
  end

  assign bcd          = r_bcd;
  assign digit_sel    = r_digit_sel;
  assign frame_commit = r_commit;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl with SCAN_DIV = 4
module tb_display_scan_ctrl;

  logic        clock;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;
  logic        frame_commit;

  int checks;
  int failures;
  int ecnt;

  display_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .value        (value),
    .load         (load),
    .blank_lz     (blank_lz),
    .bcd          (bcd),
    .digit_sel    (digit_sel),
    .frame_commit (frame_commit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ecnt numbers rising edges since reset release; edge 0 is the first one with reset low.
  task automatic step();
    @(posedge clock);
    #1;
    ecnt++;
  endtask

  task automatic step_to(input int target);
    for (int n = 0; n < 64 && ecnt < target; n++) step();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (bcd !== 4'h0 || digit_sel !== 4'b0000 || frame_commit !== 1'b0) begin
      failures++;
      $display("FAIL %s: bcd=%h digit_sel=%b frame_commit=%b required 0/0000/0", name, bcd, digit_sel, frame_commit);
    end
  endtask

  // First cycles after release: dark, then a full 4-cycle digit 0 slot, then digit 1.
  task automatic check_release(input string name);
    step();
    checks++;
    if (bcd !== 4'h0 || digit_sel !== 4'b0000 || frame_commit !== 1'b0) begin
      failures++;
      $display("FAIL %s first: bcd=%h digit_sel=%b frame_commit=%b required 0/0000/0", name, bcd, digit_sel, frame_commit);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (digit_sel !== 4'b0001) begin
        failures++;
        $display("FAIL %s slot0 edge %0d: digit_sel=%b required 0001", name, k, digit_sel);
      end
    end
    step();
    checks++;
    if (digit_sel !== 4'b0010) begin
      failures++;
      $display("FAIL %s slot1 start: digit_sel=%b required 0010", name, digit_sel);
    end
  endtask

  // Runs one frame (edges j=0..15) starting right after a frame-end edge; optional loads at j=l1_j / l2_j.
  task automatic check_frame(input string name, input logic [15:0] exp_shown, input logic [3:0] lit,
                             input int l1_j, input logic [15:0] l1_v,
                             input int l2_j, input logic [15:0] l2_v,
                             input logic exp_commit);
    logic [3:0] exp_bcd;
    logic [3:0] exp_sel;
    logic       exp_fc;
    int         slot;
    for (int j = 0; j < 16; j++) begin
      if (j == l1_j) begin value = l1_v; load = 1'b1; end
      if (j == l2_j) begin value = l2_v; load = 1'b1; end
      step();
      load = 1'b0;
      exp_bcd = exp_shown[(j / 4) * 4 +: 4];
      checks++;
      if (bcd !== exp_bcd) begin
        failures++;
        $display("FAIL %s bcd j=%0d: got %h required %h", name, j, bcd, exp_bcd);
      end
      if (j >= 1) begin
        slot = (j - 1) / 4;
        exp_sel = lit[slot] ? (4'b0001 << slot) : 4'b0000;
        checks++;
        if (digit_sel !== exp_sel) begin
          failures++;
          $display("FAIL %s digit_sel j=%0d: got %b required %b", name, j, digit_sel, exp_sel);
        end
      end
      exp_fc = (j == 15) ? exp_commit : 1'b0;
      checks++;
      if (frame_commit !== exp_fc) begin
        failures++;
        $display("FAIL %s frame_commit j=%0d: got %b required %b", name, j, frame_commit, exp_fc);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    value = 16'hFFFF;
    load  = 1'b1;
    step();
    check_zero("reset_hold_a");
    step();
    check_zero("reset_hold_b");
    load  = 1'b0;
    reset = 1'b0;
    ecnt  = -1;
    check_release("reset_release");
  endtask

  task automatic test_idle_scan();
    step_to(15);
    check_frame("idle", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0);
  endtask

  task automatic test_load_midframe();
    check_frame("load_mid_old", 16'h0000, 4'b1111, 5, 16'h1234, -1, 16'h0, 1'b1);
    check_frame("load_mid_new", 16'h1234, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0);
  endtask

  task automatic test_last_load_wins();
    check_frame("double_load_old", 16'h1234, 4'b1111, 2, 16'h1111, 9, 16'h2222, 1'b1);
    check_frame("double_load_new", 16'h2222, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0);
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    check_frame("blank_2222", 16'h2222, 4'b1111, 4, 16'h0007, -1, 16'h0, 1'b1);
    check_frame("blank_0007", 16'h0007, 4'b0001, 6, 16'h0000, -1, 16'h0, 1'b1);
    check_frame("blank_0000", 16'h0000, 4'b0001, 3, 16'h0A00, -1, 16'h0, 1'b1);
    check_frame("blank_0A00", 16'h0A00, 4'b0111, -1, 16'h0, -1, 16'h0, 1'b0);
    blank_lz = 1'b0;
  endtask

  task automatic test_frame_end_load();
    check_frame("fe_load_old", 16'h0A00, 4'b1111, 15, 16'h5678, -1, 16'h0, 1'b1);
    check_frame("fe_load_new", 16'h5678, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0);
  endtask

  task automatic test_midframe_reset();
    step(); step(); step();
    value = 16'h9999;
    load  = 1'b1;
    step();
    load  = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (bcd !== 4'h6 || digit_sel !== 4'b0010) begin
      failures++;
      $display("FAIL pre_reset_slot2: bcd=%h digit_sel=%b required 6/0010", bcd, digit_sel);
    end
    reset = 1'b1;
    value = 16'h1111;
    load  = 1'b1;
    step();
    check_zero("midframe_reset_a");
    load = 1'b0;
    step();
    check_zero("midframe_reset_b");
    reset = 1'b0;
    ecnt  = -1;
    check_release("midframe_release");
    step_to(15);
    checks++;
    if (frame_commit !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard_commit: frame_commit=%b required 0", frame_commit);
    end
    check_frame("after_reset", 16'h0000, 4'b1111, -1, 16'h0, -1, 16'h0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ecnt     = -1;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_last_load_wins();
    test_blanking();
    test_frame_end_load();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
